// File: rtl/wakeup_req_issue_pkg.sv
// Shared constants, types and helpers for the wakeup request issuer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wakeup_req_issue_pkg;

    localparam int DLAY_LEN  = 8;              // width of the one-hot delay word
    localparam int LAT_W     = 4;              // width of a request latency
    localparam int TAG_W     = 4;              // width of a request tag
    localparam int REQ_DEPTH = 4;              // default request FIFO depth
    localparam int WD_LIMIT  = DLAY_LEN + 1;   // watchdog value that declares a lost wakeup
    localparam int WD_W      = $clog2(WD_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    // One queued request; latency is already clamped when it is stored.
    typedef struct packed {
        logic [LAT_W-1:0] lat;
        logic [TAG_W-1:0] tag;
    } req_t;

    function automatic logic lat_over(input logic [LAT_W-1:0] lat);
        return lat >= LAT_W'(DLAY_LEN);
    endfunction

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        return lat_over(lat) ? LAT_W'(DLAY_LEN - 1) : lat;
    endfunction

    // Latency n becomes a single set bit at position n of the delay word.
    function automatic logic [DLAY_LEN-1:0] enc_wdy(input logic [LAT_W-1:0] lat);
        return DLAY_LEN'(1) << lat;
    endfunction

endpackage

// File: rtl/wakeup_req_fifo.sv
// Synchronous request FIFO, DEPTH x W, read data is the current head.
// Latency: a push is visible at the head one cycle later.
// Backpressure: full/empty flags; push when full and pop when empty are ignored.
module wakeup_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    // Pointer update; guarded so misuse cannot corrupt occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wakeup_req_issue.sv
// Queues tagged wakeup requests, issues one-hot delay words, returns tags on wakeup.
// Latency: wdy_load 2 cycles after a push into an idle block; wake_out 1 cycle after wake_in.
// Backpressure: req_ready drops while the FIFO is full, even during a same-cycle pop.
module wakeup_req_issue
    import wakeup_req_issue_pkg::*;
#(
    parameter int DEPTH = REQ_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LAT_W-1:0]    req_lat,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                wdy_load,
    output logic [DLAY_LEN-1:0] wdy,
    input  logic                wake_in,
    output logic                wake_out,
    output logic [TAG_W-1:0]    wake_tag,
    output logic                err_clamp,
    output logic                err_tmo,
    output logic                err_spur
);

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q;
    logic [TAG_W-1:0] tag_q;
    req_t             push_dat;
    req_t             head;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic             load_next, do_wake, do_tmo;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign push_dat  = '{lat: clamp_lat(req_lat), tag: req_tag};

    wakeup_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_dat),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and per-cycle strobes; a wakeup in the expiry cycle beats the timeout.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_next = 1'b0;
        do_wake   = 1'b0;
        do_tmo    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_next = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (wake_in) begin
                    do_wake = 1'b1;
                    state_d = IDLE;
                end else if (wd_q == WD_W'(WD_LIMIT)) begin
                    do_tmo  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Registered outputs, watchdog, in-flight tag and sticky error flags.
    // wdy/wdy_load are set on the IDLE->LOAD edge so they are high exactly during LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdy_load  <= 1'b0;
            wdy       <= '0;
            wake_out  <= 1'b0;
            wake_tag  <= '0;
            wd_q      <= '0;
            tag_q     <= '0;
            err_clamp <= 1'b0;
            err_tmo   <= 1'b0;
            err_spur  <= 1'b0;
        end else begin
            wdy_load <= load_next;
            wdy      <= load_next ? enc_wdy(head.lat) : '0;
            wake_out <= do_wake;
            wake_tag <= do_wake ? tag_q : '0;
            if (pop) begin
                tag_q <= head.tag;
                wd_q  <= '0;
            end else if (state_q == WAIT) begin
                wd_q  <= wd_q + WD_W'(1);
            end
            if (push && lat_over(req_lat))
                err_clamp <= 1'b1;
            if (do_tmo)
                err_tmo <= 1'b1;
            if (wake_in && (state_q != WAIT))
                err_spur <= 1'b1;
        end
    end

endmodule
